// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared types and constants for the memory access sequencer.
// State encoding, request opcodes and the response error flag value.
package memory_access_pkg;

   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_WAIT_COMPUTE = 3'd1;
   localparam logic [2:0] S_ACCESS       = 3'd2;
   localparam logic [2:0] S_READ_WAIT    = 3'd3;
   localparam logic [2:0] S_RESPOND      = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE         = S_IDLE,
      ST_WAIT_COMPUTE = S_WAIT_COMPUTE,
      ST_ACCESS       = S_ACCESS,
      ST_READ_WAIT    = S_READ_WAIT,
      ST_RESPOND      = S_RESPOND
   } state_e;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   localparam logic RSP_OK    = 1'b0;
   localparam logic RSP_ERROR = 1'b1;

endpackage

// File: rtl/memory_access_sequencer_if.sv
// memory_access_sequencer_if: host request/response channel of the sequencer.
// Handshake: a request transfers on a clock edge where req_valid && req_ready;
// a response transfers on a clock edge where rsp_valid && rsp_ready. A sender
// holds its payload stable while valid is high and the transfer has not happened.
interface memory_access_sequencer_if #(
   parameter int CODE_BIT_WIDTH          = 3,
   parameter int START_ADDRESS_BIT_WIDTH = 14,
   parameter int MESSAGE_BIT_WIDTH       = 32
);
   logic                               req_valid;
   logic                               req_ready;
   logic                               req_write;
   logic [CODE_BIT_WIDTH-1:0]          req_code;
   logic [START_ADDRESS_BIT_WIDTH-1:0] req_address;
   logic [MESSAGE_BIT_WIDTH-1:0]       req_data;
   logic                               rsp_valid;
   logic                               rsp_ready;
   logic [MESSAGE_BIT_WIDTH-1:0]       rsp_data;
   logic                               rsp_error;

   // Host side (SPI command decoder)
   modport master (
      output req_valid, req_write, req_code, req_address, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_error
   );

   // Sequencer side
   modport slave (
      input  req_valid, req_write, req_code, req_address, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_error
   );
endinterface

// File: rtl/memory_read_select.sv
// memory_read_select: picks the MESSAGE_BIT_WIDTH slice of the concatenated
// memory manager outputs addressed by code. Codes with no memory return 0.
module memory_read_select #(
   parameter int NUM_MEMORIES      = 4,
   parameter int CODE_BIT_WIDTH    = 3,
   parameter int MESSAGE_BIT_WIDTH = 32
) (
   input  logic [CODE_BIT_WIDTH-1:0]                 code,
   input  logic [NUM_MEMORIES*MESSAGE_BIT_WIDTH-1:0] data_in,
   output logic [MESSAGE_BIT_WIDTH-1:0]              data_out
);

   // One-hot compare against every memory index; unmatched code yields 0
   always_comb begin
      data_out = '0;
      for (int i = 0; i < NUM_MEMORIES; i++) begin
         if (code == CODE_BIT_WIDTH'(i)) begin
            data_out = data_in[i*MESSAGE_BIT_WIDTH +: MESSAGE_BIT_WIDTH];
         end
      end
   end

endmodule

// File: rtl/memory_access_sequencer.sv
// memory_access_sequencer: serialises host read/write requests onto the
// memory managers, holding off the compute controller around each access.
// Optional build macro MEMORY_ACCESS_SEQUENCER_TIMEOUT_EN bounds the wait for
// compute to go idle to TIMEOUT_CYCLES cycles and answers with an error.
module memory_access_sequencer
   import memory_access_pkg::*;
#(
   parameter int NUM_MEMORIES            = 4,
   parameter int CODE_BIT_WIDTH          = 3,
   parameter int START_ADDRESS_BIT_WIDTH = 14,
   parameter int MESSAGE_BIT_WIDTH       = 32,
   parameter int READ_LATENCY            = 1,
   parameter int TIMEOUT_CYCLES          = 1024
) (
   input  logic                                      clk,
   input  logic                                      rst,
   memory_access_sequencer_if.slave                  host,
   input  logic                                      compute_busy,
   output logic                                      compute_hold,
   output logic                                      program_memory_new,
   output logic                                      read_memory_sync,
   output logic [CODE_BIT_WIDTH-1:0]                 memory_code,
   output logic [START_ADDRESS_BIT_WIDTH-1:0]        spi_address,
   output logic [MESSAGE_BIT_WIDTH-1:0]              spi_data_in,
   input  logic [NUM_MEMORIES*MESSAGE_BIT_WIDTH-1:0] spi_data_out_all,
   output state_e                                    dbg_state
);

   localparam int LAT_W = $clog2(READ_LATENCY + 1);

   if (READ_LATENCY < 1 || (2 ** CODE_BIT_WIDTH) < NUM_MEMORIES || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("memory_access_sequencer: illegal parameter combination");
   end

   state_e                               state_q, state_d;
   logic                                 write_q, write_d;
   logic [CODE_BIT_WIDTH-1:0]            code_q, code_d;
   logic [START_ADDRESS_BIT_WIDTH-1:0]   addr_q, addr_d;
   logic [MESSAGE_BIT_WIDTH-1:0]         wdata_q, wdata_d;
   logic                                 rsp_valid_q, rsp_valid_d;
   logic                                 rsp_error_q, rsp_error_d;
   logic [MESSAGE_BIT_WIDTH-1:0]         rsp_data_q, rsp_data_d;
   logic                                 hold_q, hold_d;
   logic                                 prog_q, prog_d;
   logic                                 rd_q, rd_d;
   logic [LAT_W-1:0]                     lat_cnt_q, lat_cnt_d;
   logic [MESSAGE_BIT_WIDTH-1:0]         sel_data;
   logic                                 code_bad;

`ifdef MEMORY_ACCESS_SEQUENCER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0]                     tmo_cnt_q, tmo_cnt_d;
`endif

   memory_read_select #(
      .NUM_MEMORIES      (NUM_MEMORIES),
      .CODE_BIT_WIDTH    (CODE_BIT_WIDTH),
      .MESSAGE_BIT_WIDTH (MESSAGE_BIT_WIDTH)
   ) u_read_select (
      .code     (code_q),
      .data_in  (spi_data_out_all),
      .data_out (sel_data)
   );

   // Codes beyond the populated memories are rejected without touching any manager
   assign code_bad = ({1'b0, host.req_code} >= (CODE_BIT_WIDTH + 1)'(NUM_MEMORIES));

   // Next-state and registered-output computation
   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      code_d      = code_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_error_d = rsp_error_q;
      rsp_data_d  = rsp_data_q;
      hold_d      = hold_q;
      prog_d      = 1'b0;
      rd_d        = 1'b0;
      lat_cnt_d   = lat_cnt_q;
`ifdef MEMORY_ACCESS_SEQUENCER_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (host.req_valid) begin
               write_d = host.req_write;
               code_d  = host.req_code;
               addr_d  = host.req_address;
               wdata_d = host.req_data;
               if (code_bad) begin
                  rsp_valid_d = 1'b1;
                  rsp_error_d = RSP_ERROR;
                  rsp_data_d  = '0;
                  state_d     = ST_RESPOND;
               end else begin
                  hold_d  = 1'b1;
                  state_d = ST_WAIT_COMPUTE;
`ifdef MEMORY_ACCESS_SEQUENCER_TIMEOUT_EN
                  tmo_cnt_d = '0;
`endif
               end
            end
         end
         ST_WAIT_COMPUTE: begin
            // The pulse is registered on entry so it is high for exactly the ACCESS cycle
            if (!compute_busy) begin
               prog_d  = (write_q == OP_WRITE);
               rd_d    = (write_q == OP_READ);
               state_d = ST_ACCESS;
            end
`ifdef MEMORY_ACCESS_SEQUENCER_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_valid_d = 1'b1;
               rsp_error_d = RSP_ERROR;
               rsp_data_d  = '0;
               state_d     = ST_RESPOND;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end
         ST_ACCESS: begin
            if (write_q == OP_WRITE) begin
               rsp_valid_d = 1'b1;
               rsp_error_d = RSP_OK;
               rsp_data_d  = '0;
               state_d     = ST_RESPOND;
            end else begin
               lat_cnt_d = LAT_W'(READ_LATENCY);
               state_d   = ST_READ_WAIT;
            end
         end
         ST_READ_WAIT: begin
            // Counter reaching 1 marks the cycle the managers present valid data
            if (lat_cnt_q == LAT_W'(1)) begin
               rsp_valid_d = 1'b1;
               rsp_error_d = RSP_OK;
               rsp_data_d  = sel_data;
               state_d     = ST_RESPOND;
            end
            lat_cnt_d = lat_cnt_q - 1'b1;
         end
         ST_RESPOND: begin
            if (host.rsp_ready) begin
               rsp_valid_d = 1'b0;
               hold_d      = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         write_q     <= 1'b0;
         code_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_data_q  <= '0;
         hold_q      <= 1'b0;
         prog_q      <= 1'b0;
         rd_q        <= 1'b0;
         lat_cnt_q   <= '0;
`ifdef MEMORY_ACCESS_SEQUENCER_TIMEOUT_EN
         tmo_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         code_q      <= code_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_data_q  <= rsp_data_d;
         hold_q      <= hold_d;
         prog_q      <= prog_d;
         rd_q        <= rd_d;
         lat_cnt_q   <= lat_cnt_d;
`ifdef MEMORY_ACCESS_SEQUENCER_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
`endif
      end
   end

   assign host.req_ready     = (state_q == ST_IDLE) && !rst;
   assign host.rsp_valid     = rsp_valid_q;
   assign host.rsp_error     = rsp_error_q;
   assign host.rsp_data      = rsp_data_q;
   assign compute_hold       = hold_q;
   assign program_memory_new = prog_q;
   assign read_memory_sync   = rd_q;
   assign memory_code        = code_q;
   assign spi_address        = addr_q;
   assign spi_data_in        = wdata_q;
   assign dbg_state          = state_q;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// tb_memory_access_sequencer: randomized and directed checks of the sequencer
// against a cycle-timeline reference derived from the access rules.
module tb_memory_access_sequencer;
   import memory_access_pkg::*;

   localparam int NUM = 4;
   localparam int CW  = 3;
   localparam int AW  = 14;
   localparam int DW  = 32;
   localparam int RL  = 2;
   localparam int TMO = 16;

   logic            clk;
   logic            rst;
   logic            compute_busy;
   logic            compute_hold;
   logic            program_memory_new;
   logic            read_memory_sync;
   logic [CW-1:0]   memory_code;
   logic [AW-1:0]   spi_address;
   logic [DW-1:0]   spi_data_in;
   logic [NUM*DW-1:0] spi_data_out_all;
   state_e          dbg_state;

   int n_checks;
   int n_bad;

   memory_access_sequencer_if #(.CODE_BIT_WIDTH(CW), .START_ADDRESS_BIT_WIDTH(AW),
                                .MESSAGE_BIT_WIDTH(DW)) host_if ();

   memory_access_sequencer #(
      .NUM_MEMORIES            (NUM),
      .CODE_BIT_WIDTH          (CW),
      .START_ADDRESS_BIT_WIDTH (AW),
      .MESSAGE_BIT_WIDTH       (DW),
      .READ_LATENCY            (RL),
      .TIMEOUT_CYCLES          (TMO)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .host               (host_if.slave),
      .compute_busy       (compute_busy),
      .compute_hold       (compute_hold),
      .program_memory_new (program_memory_new),
      .read_memory_sync   (read_memory_sync),
      .memory_code        (memory_code),
      .spi_address        (spi_address),
      .spi_data_in        (spi_data_in),
      .spi_data_out_all   (spi_data_out_all),
      .dbg_state          (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic fill_mem_outputs();
      for (int i = 0; i < NUM; i++) spi_data_out_all[i*DW +: DW] = $urandom();
   endtask

   // Runs one request and checks every output each cycle against a timeline
   // derived from the access rules: cycle 0 is the accept cycle.
   task automatic run_txn(input bit wr, input int code, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input int busy_len, input int rsp_delay);
      bit bad, tmo;
      int acc_c, rsp_c, done_c;
      logic [DW-1:0] exp_data;
      bit e_prog, e_rd, e_hold, e_rv, e_rr;
      bad = (code >= NUM);
      tmo = 1'b0;
`ifdef MEMORY_ACCESS_SEQUENCER_TIMEOUT_EN
      tmo = !bad && (busy_len >= TMO);
`endif
      acc_c = -1;
      if (bad) rsp_c = 1;
      else if (tmo) rsp_c = TMO + 1;
      else begin
         acc_c = busy_len + 2;
         rsp_c = wr ? acc_c + 1 : acc_c + 1 + RL;
      end
      done_c = rsp_c + rsp_delay;
      exp_data = '0;

      @(negedge clk);
      n_checks++;
      if (host_if.req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL req_ready_before_accept: got %b want 1", host_if.req_ready);
      end
      host_if.req_valid   = 1'b1;
      host_if.req_write   = wr;
      host_if.req_code    = CW'(code);
      host_if.req_address = addr;
      host_if.req_data    = data;
      host_if.rsp_ready   = 1'b0;
      compute_busy        = 1'b0;
      fill_mem_outputs();

      for (int c = 1; c <= done_c + 1; c++) begin
         @(negedge clk);
         // Noise on the request channel must be ignored while busy
         host_if.req_valid   = (c <= done_c) ? 1'($urandom_range(0, 1)) : 1'b0;
         host_if.req_write   = 1'($urandom_range(0, 1));
         host_if.req_code    = CW'($urandom_range(0, 7));
         host_if.req_address = AW'($urandom());
         host_if.req_data    = $urandom();
         compute_busy        = (c <= busy_len);
         host_if.rsp_ready   = (c == done_c);
         fill_mem_outputs();
         if (!bad && !tmo && !wr && c == acc_c + RL) exp_data = spi_data_out_all[code*DW +: DW];

         e_prog = !bad && !tmo && wr && (c == acc_c);
         e_rd   = !bad && !tmo && !wr && (c == acc_c);
         e_hold = !bad && (c <= done_c);
         e_rv   = (c >= rsp_c) && (c <= done_c);
         e_rr   = (c > done_c);

         n_checks++;
         if (program_memory_new !== e_prog) begin
            n_bad++;
            $display("FAIL program_pulse c=%0d: got %b want %b", c, program_memory_new, e_prog);
         end
         n_checks++;
         if (read_memory_sync !== e_rd) begin
            n_bad++;
            $display("FAIL read_pulse c=%0d: got %b want %b", c, read_memory_sync, e_rd);
         end
         n_checks++;
         if (compute_hold !== e_hold) begin
            n_bad++;
            $display("FAIL compute_hold c=%0d: got %b want %b", c, compute_hold, e_hold);
         end
         n_checks++;
         if (host_if.rsp_valid !== e_rv) begin
            n_bad++;
            $display("FAIL rsp_valid c=%0d: got %b want %b", c, host_if.rsp_valid, e_rv);
         end
         n_checks++;
         if (host_if.req_ready !== e_rr) begin
            n_bad++;
            $display("FAIL req_ready c=%0d: got %b want %b", c, host_if.req_ready, e_rr);
         end
         if (e_rv) begin
            n_checks++;
            if (host_if.rsp_data !== exp_data) begin
               n_bad++;
               $display("FAIL rsp_data c=%0d: got %h want %h", c, host_if.rsp_data, exp_data);
            end
            n_checks++;
            if (host_if.rsp_error !== (bad || tmo)) begin
               n_bad++;
               $display("FAIL rsp_error c=%0d: got %b want %b", c, host_if.rsp_error, (bad || tmo));
            end
         end
         if (c <= done_c) begin
            n_checks++;
            if (memory_code !== CW'(code) || spi_address !== addr || spi_data_in !== data) begin
               n_bad++;
               $display("FAIL latched_fields c=%0d: got code=%0d addr=%h data=%h want code=%0d addr=%h data=%h",
                        c, memory_code, spi_address, spi_data_in, code, addr, data);
            end
         end
      end
      host_if.req_valid = 1'b0;
      host_if.rsp_ready = 1'b0;
      compute_busy      = 1'b0;
   endtask

   task automatic test_reset();
      rst               = 1'b1;
      host_if.req_valid = 1'b0;
      host_if.req_write = 1'b0;
      host_if.req_code  = '0;
      host_if.req_address = '0;
      host_if.req_data  = '0;
      host_if.rsp_ready = 1'b0;
      compute_busy      = 1'b0;
      spi_data_out_all  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({host_if.rsp_valid, host_if.rsp_error, compute_hold, program_memory_new, read_memory_sync,
           host_if.req_ready} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 000000", {host_if.rsp_valid, host_if.rsp_error,
                  compute_hold, program_memory_new, read_memory_sync, host_if.req_ready});
      end
      n_checks++;
      if (memory_code !== '0 || spi_address !== '0 || spi_data_in !== '0 || host_if.rsp_data !== '0) begin
         n_bad++;
         $display("FAIL reset_data: got code=%0d addr=%h data=%h rsp=%h want all 0",
                  memory_code, spi_address, spi_data_in, host_if.rsp_data);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (host_if.req_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
         n_bad++;
         $display("FAIL reset_release: got ready=%b state=%0d want ready=1 state=%0d",
                  host_if.req_ready, dbg_state, ST_IDLE);
      end
   endtask

   task automatic test_write();
      run_txn(1'b1, 2, 14'h0005, 32'hDEADBEEF, 0, 0);
   endtask

   task automatic test_read();
      run_txn(1'b0, 1, 14'h0123, 32'h0, 0, 0);
      run_txn(1'b0, 3, 14'h3FFF, 32'hFFFF_FFFF, 0, 1);
   endtask

   task automatic test_bad_code();
      run_txn(1'b0, 5, 14'h0010, 32'h0, 0, 0);
      run_txn(1'b1, 4, 14'h0011, 32'hCAFE_F00D, 3, 2);
   endtask

   task automatic test_compute_busy();
      run_txn(1'b1, 0, 14'h0042, 32'h1357_9BDF, 10, 0);
      run_txn(1'b0, 2, 14'h0043, 32'h0, 10, 0);
   endtask

   task automatic test_rsp_backpressure();
      run_txn(1'b0, 0, 14'h0777, 32'h0, 0, 7);
   endtask

   // Reset in the middle of an access leaves no pulse or hold behind
   task automatic test_reset_mid();
      @(negedge clk);
      host_if.req_valid   = 1'b1;
      host_if.req_write   = 1'b1;
      host_if.req_code    = 3'd3;
      host_if.req_address = 14'h0AAA;
      host_if.req_data    = 32'h5555_AAAA;
      compute_busy        = 1'b1;
      repeat (3) begin
         @(negedge clk);
         host_if.req_valid = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({host_if.rsp_valid, host_if.rsp_error, compute_hold, program_memory_new, read_memory_sync} !== 5'b0 ||
          memory_code !== '0 || spi_address !== '0 || spi_data_in !== '0 || host_if.rsp_data !== '0) begin
         n_bad++;
         $display("FAIL reset_mid: got flags=%b code=%0d addr=%h data=%h want all 0",
                  {host_if.rsp_valid, host_if.rsp_error, compute_hold, program_memory_new, read_memory_sync},
                  memory_code, spi_address, spi_data_in);
      end
      rst          = 1'b0;
      compute_busy = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks++;
         if ({compute_hold, program_memory_new, read_memory_sync, host_if.rsp_valid} !== 4'b0 ||
             host_if.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_after c=%0d: got hold/prog/rd/rv=%b ready=%b want 0000 1", c,
                     {compute_hold, program_memory_new, read_memory_sync, host_if.rsp_valid}, host_if.req_ready);
         end
      end
   endtask

   task automatic test_timeout();
`ifdef MEMORY_ACCESS_SEQUENCER_TIMEOUT_EN
      run_txn(1'b1, 1, 14'h0100, 32'h0BAD_0BAD, TMO + 5, 1);
      run_txn(1'b0, 2, 14'h0101, 32'h0, TMO - 1, 0);
`endif
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         run_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), AW'($urandom()), $urandom(),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      n_checks = 0;
      n_bad    = 0;
      test_reset();
      test_write();
      test_read();
      test_bad_code();
      test_compute_busy();
      test_rsp_backpressure();
      test_reset_mid();
      test_timeout();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
